// File: rtl/tpu_host_master.sv
// Bus initiator for the 8x8 TPU: loads A, B and C rows from an input stream,
// triggers the multiply, then streams the C half-rows back out.
module tpu_host_master #(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int WAIT_CYC = 24,
  parameter int RD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_c,
  output logic             busy,
  output logic             done,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [ADDRW-1:0] bus_addr,
  output logic [DATAW-1:0] bus_wdata,
  output logic             bus_r_w,
  input  logic [DATAW-1:0] bus_rdata
);

  localparam int IW = $clog2(2 * DIM);
  localparam int CW = $clog2(WAIT_CYC + RD_LAT + 1);

  localparam logic [IW-1:0]    ROW_LAST  = IW'(DIM - 1);
  localparam logic [IW-1:0]    WORD_LAST = IW'(2 * DIM - 1);
  localparam logic [CW-1:0]    WAIT_LAST = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0]    RD_LAST   = CW'(RD_LAT);
  localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] TRIG_ADDR = ADDRW'(16'h0400);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, LD_C, GO, WAIT, RD, OUT} state_t;

  state_t           state;
  state_t           ld_next;
  logic             load_c_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [ADDRW-1:0] ld_base;
  logic [IW-1:0]    ld_last;
  logic             in_hs;
  logic             ld_write;

  function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                 input logic [IW-1:0] i);
    return base + ADDRW'({i, 3'b000});
  endfunction

  assign busy     = (state != IDLE);
  assign in_ready = (state == LD_A) || (state == LD_B) || ((state == LD_C) && load_c_q);
  assign in_hs    = in_valid && in_ready;
  // Without C-init data the C phase writes one zero word every cycle.
  assign ld_write = in_hs || ((state == LD_C) && !load_c_q);

  always_comb begin
    ld_base = A_BASE;
    ld_last = ROW_LAST;
    ld_next = LD_B;
    case (state)
      LD_B: begin
        ld_base = B_BASE;
        ld_next = LD_C;
      end
      LD_C: begin
        ld_base = C_BASE;
        ld_last = WORD_LAST;
        ld_next = GO;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      load_c_q  <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_r_w   <= 1'b0;
    end else begin
      done      <= 1'b0;
      bus_r_w   <= 1'b0;
      bus_wdata <= '0;
      case (state)
        IDLE: begin
          bus_addr <= '0;
          if (start) begin
            load_c_q <= load_c;
            idx      <= '0;
            state    <= LD_A;
          end
        end
        LD_A, LD_B, LD_C: begin
          if (ld_write) begin
            bus_r_w   <= 1'b1;
            bus_addr  <= word_addr(ld_base, idx);
            bus_wdata <= in_hs ? in_data : '0;
            if (idx == ld_last) begin
              idx   <= '0;
              state <= ld_next;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            bus_addr <= '0;
          end
        end
        GO: begin
          bus_r_w  <= 1'b1;
          bus_addr <= TRIG_ADDR;
          cnt      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          bus_addr <= '0;
          if (cnt == WAIT_LAST) begin
            cnt      <= '0;
            idx      <= '0;
            bus_addr <= C_BASE;
            state    <= RD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // The read address is held through OUT so a stalled word keeps its source visible.
        RD: begin
          if (cnt == RD_LAST) begin
            out_data  <= bus_rdata;
            out_valid <= 1'b1;
            out_last  <= (idx == WORD_LAST);
            state     <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == WORD_LAST) begin
              done     <= 1'b1;
              bus_addr <= '0;
              state    <= IDLE;
            end else begin
              idx      <= idx + IW'(1);
              cnt      <= '0;
              bus_addr <= word_addr(C_BASE, idx + IW'(1));
              state    <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_master.sv
// Scoreboard bench for tpu_host_master with a behavioural TPU on the bus side.
module tb_tpu_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_c = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready;
  logic        busy, done, in_ready, out_valid, out_last, bus_r_w;
  logic [63:0] out_data, bus_wdata, bus_rdata;
  logic [15:0] bus_addr;

  always #5 clk = ~clk;

  tpu_host_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_c(load_c),
    .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_r_w(bus_r_w), .bus_rdata(bus_rdata)
  );

  typedef struct { logic [15:0] addr; logic [63:0] data; } wr_t;
  typedef struct { logic [63:0] data; logic last; } out_t;

  int          checks = 0;
  int          errors = 0;
  int          a_m [8][8];
  int          b_m [8][8];
  int          c_init = 0;
  logic [63:0] words [$];
  wr_t         exp_w [$];
  out_t        exp_o [$];
  wr_t         ew;
  out_t        eo;
  int          cyc = 0;
  int          hs_count = 0;
  int          stall_word = -1;
  int          stalled = 0;
  int          t_start = 0;
  int          t_end = 0;
  logic        job_done = 1'b0;
  logic        pending_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  // Behavioural TPU: row registers, accumulate-on-trigger, combinational C read.
  logic [63:0] tpu_a [8];
  logic [63:0] tpu_b [8];
  logic [63:0] tpu_c [16];

  function automatic logic [15:0] tpu_dot(input int r, input int c);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 8; k++)
      s = s + 16'(tpu_a[r][8*k +: 8]) * 16'(tpu_b[k][8*c +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (bus_r_w) begin
      case (bus_addr[11:8])
        4'h1: tpu_a[bus_addr[5:3]] <= bus_wdata;
        4'h2: tpu_b[bus_addr[5:3]] <= bus_wdata;
        4'h3: tpu_c[bus_addr[6:3]] <= bus_wdata;
        4'h4: for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                  tpu_c[2*r + c/4][16*(c%4) +: 16] <= tpu_c[2*r + c/4][16*(c%4) +: 16] + tpu_dot(r, c);
        default: ;
      endcase
    end
  end

  assign bus_rdata = (bus_addr[11:8] == 4'h3) ? tpu_c[bus_addr[6:3]] : 64'h0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an unexpected event, required none", name);
  endtask

  function automatic logic [63:0] a_row(input int i);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(a_m[i][k]);
    return w;
  endfunction

  function automatic logic [63:0] b_row(input int i);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(b_m[i][k]);
    return w;
  endfunction

  function automatic logic [63:0] exp_c_word(input int j, input int ci);
    logic [63:0] w;
    int s;
    for (int l = 0; l < 4; l++) begin
      s = ci;
      for (int k = 0; k < 8; k++) s += a_m[j/2][k] * b_m[k][(j%2)*4 + l];
      w[16*l +: 16] = 16'(s);
    end
    return w;
  endfunction

  task automatic push_wr(input int addr, input logic [63:0] data);
    wr_t w;
    w.addr = 16'(addr);
    w.data = data;
    exp_w.push_back(w);
  endtask

  task automatic build_job(input bit lc);
    out_t o;
    logic [63:0] cw;
    words.delete(); exp_w.delete(); exp_o.delete();
    for (int i = 0; i < 8; i++) begin
      words.push_back(a_row(i));
      push_wr(16'h0100 + 8*i, a_row(i));
    end
    for (int i = 0; i < 8; i++) begin
      words.push_back(b_row(i));
      push_wr(16'h0200 + 8*i, b_row(i));
    end
    cw = lc ? {4{16'(c_init)}} : 64'h0;
    for (int j = 0; j < 16; j++) begin
      if (lc) words.push_back(cw);
      push_wr(16'h0300 + 8*j, cw);
    end
    push_wr(16'h0400, 64'h0);
    for (int j = 0; j < 16; j++) begin
      o.data = exp_c_word(j, lc ? c_init : 0);
      o.last = (j == 15);
      exp_o.push_back(o);
    end
  endtask

  task automatic pulse_start(input bit lc);
    @(posedge clk); #2;
    start = 1'b1;
    load_c = lc;
    @(posedge clk); #2;
    t_start = cyc;
    start = 1'b0;
    load_c = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int n, input bit throttle);
    int w;
    for (int i = 0; i < n; i++) begin
      if (throttle) begin
        in_valid = 1'b0;
        @(posedge clk); #2;
        checkOutput("idle_bus_cycle", bus_r_w, 0);
      end
      in_valid = 1'b1;
      in_data = words[i];
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #2;
        w++;
      end
      if (w == 50) begin
        failNow("in_ready_timeout");
        break;
      end
      @(posedge clk); #2;
      checkOutput("write_strobe", bus_r_w, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit lc, input bit throttle, input int stall, input bit poke);
    int n;
    build_job(lc);
    hs_count = 0;
    stalled = 0;
    stall_word = stall;
    job_done = 1'b0;
    pulse_start(lc);
    feed(words.size(), throttle);
    if (poke) begin
      in_valid = 1'b1;
      in_data = 64'hDEAD_BEEF_0BAD_F00D;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #2;
        checkOutput("in_ready_outside_load", in_ready, 0);
      end
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    n = 0;
    while (!job_done && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    in_valid = 1'b0;
    checkOutput("job_completed", job_done, 1);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("writes_left", 64'(exp_w.size()), 0);
    checkOutput("outputs_left", 64'(exp_o.size()), 0);
    if (!throttle && stall < 0)
      checkOutput("job_length", 64'(t_end - t_start + 2), 64'(1 + 32 + 1 + 24 + 16*3));
    stall_word = -1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output backpressure: hold out_ready low for 5 cycles on the selected word.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stall_word >= 0 && out_valid && hs_count == stall_word && stalled < 5) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus_r_w) begin
      if (exp_w.size() == 0) begin
        failNow("bus_extra_write");
      end else begin
        ew = exp_w.pop_front();
        checkOutput("bus_write_addr", 64'(bus_addr), 64'(ew.addr));
        checkOutput("bus_write_data", bus_wdata, ew.data);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pending_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pending_done) begin
        checkOutput("done_pulse", done, 1);
        pending_done = 1'b0;
        job_done = 1'b1;
      end else if (done) begin
        failNow("done_spurious");
      end
      if (prev_stall) begin
        checkOutput("stall_hold_valid", out_valid, 1);
        checkOutput("stall_hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready)
        checkOutput("stall_read_addr", 64'(bus_addr), 64'(16'h0300 + 8*hs_count));
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_o.size() == 0) begin
          failNow("out_extra_word");
        end else begin
          eo = exp_o.pop_front();
          checkOutput("out_data", out_data, eo.data);
          checkOutput("out_last", out_last, eo.last);
          if (eo.last) begin
            pending_done = 1'b1;
            t_end = cyc;
          end
        end
        hs_count++;
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_last"}, out_last, 0);
    checkOutput({tag, "_bus_r_w"}, bus_r_w, 0);
    checkOutput({tag, "_bus_addr"}, 64'(bus_addr), 0);
    checkOutput({tag, "_bus_wdata"}, bus_wdata, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        a_m[i][k] = (i == k) ? 1 : 0;
        b_m[i][k] = 8*i + k + 1;
      end

    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    $display("[TB] job 1: identity A, zero C");
    applyStimulus(1'b0, 1'b0, -1, 1'b0);

    $display("[TB] job 2: throttled input, stall on word 3");
    applyStimulus(1'b0, 1'b1, 3, 1'b0);

    $display("[TB] job 3: C-init from stream, start and in_valid poked mid-job");
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++)
        a_m[i][k] = ((i == k) ? 2 : 0) + ((k == (i + 1) % 8) ? 1 : 0);
    c_init = 1;
    applyStimulus(1'b1, 1'b0, -1, 1'b1);

    $display("[TB] reset during LD_B");
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++)
        a_m[i][k] = (i == k) ? 1 : 0;
    c_init = 0;
    build_job(1'b0);
    while (exp_w.size() > 11) void'(exp_w.pop_back());
    exp_o.delete();
    hs_count = 0;
    pulse_start(1'b0);
    feed(11, 1'b0);
    checkOutput("abort_third_b_addr", 64'(bus_addr), 64'h0210);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    checkOutput("abort_writes_left", 64'(exp_w.size()), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    $display("[TB] job 4: fresh job after abort");
    applyStimulus(1'b0, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_host_master.md
# tpu_host_master

Bus initiator that drives the memory-mapped port of the 8x8 TPU (`tpuv1`) in the opposite direction from the TPU's responder role. After a `start` pulse it runs one full matrix-multiply job:
- streams A, B and C-initial rows from an input valid/ready stream into the TPU;
- issues the multiply trigger and waits out the array latency;
- reads back all C half-rows and presents them on an output valid/ready stream.

It sits between a host-side data mover and the TPU.

## Interface
Parameters:
- DIM, 8: matrix dimension.
- DATAW, 64: bus and stream data width.
- ADDRW, 16: bus address width.
- WAIT_CYC, 24: cycles spent in WAIT after the trigger write. Must be ≥ 3*DIM-2.
- RD_LAT, 1: cycles from presenting a read address to the cycle whose end samples `bus_rdata`.

Ports:
- clk  in  1  clock; one clock domain only.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request. Ignored unless in IDLE.
- load_c  in  1  sampled with `start`. 1: C-init words come from the input stream. 0: zeros are written to C and no C words are consumed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last output word handshakes.
- in_data  in  DATAW  input stream data.
- in_valid  in  1  input word available.
- in_ready  out  1  high only in LD_A, LD_B, and LD_C when `load_c`=1.
- out_data  out  DATAW  C half-row read back from the TPU.
- out_valid  out  1  out_data valid; held until out_ready.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  high with the 16th (final) output word.
- bus_addr  out  ADDRW  TPU address, registered.
- bus_wdata  out  DATAW  TPU write data, registered.
- bus_r_w  out  1  1 = write, 0 = read; registered.
- bus_rdata  in  DATAW  TPU read data (combinational from `bus_addr`).

## Operation
- Address map:
  - A row i: 0x0100 + 8*i, i = 0..DIM-1.
  - B row i: 0x0200 + 8*i.
  - C word j: 0x0300 + 8*j, j = 0..2*DIM-1. Even j is the low half of row j/2; odd j is the high half.
  - Trigger: write to 0x0400; the data value is don't-care and is driven as 0.
- States: IDLE → LD_A → LD_B → LD_C → GO → WAIT → RD → OUT → (RD or IDLE).
- IDLE: bus idle (`bus_r_w`=0, `bus_addr`=0, `bus_wdata`=0). On `start`=1, latch `load_c`, clear the word index, go to LD_A.
- LD_A / LD_B: each input handshake (`in_valid` && `in_ready`) registers a bus write on the next cycle.
  - The write carries that data to the current row address; the index then increments.
  - After index DIM-1 is accepted, advance to the next state and clear the index.
  - Cycles with no handshake drive a bus idle cycle (`bus_r_w`=0).
- LD_C: 2*DIM writes.
  - `load_c`=1: data comes from the stream, with the same handshake rules as LD_A/LD_B.
  - `load_c`=0: one zero-data write per cycle, with `in_ready`=0.
- GO: one cycle writing the trigger address; then go to WAIT with the counter cleared.
- WAIT: bus idle for WAIT_CYC cycles, then go to RD with j=0.
- RD: drive `bus_addr` = C word j with `bus_r_w`=0. Hold it for RD_LAT+1 cycles, then capture `bus_rdata` into `out_data`, set `out_valid`, and go to OUT.
- OUT: hold `out_data` and `out_valid` until `out_ready`.
  - On handshake with j < 2*DIM-1: j++, go to RD.
  - On handshake with j = 2*DIM-1: `out_last` was high; pulse `done`, go to IDLE.
- `bus_addr` holds its RD value through OUT; this is harmless because it is a read.

## Timing
- Reset values: `busy`, `done`, `in_ready`, `out_valid`, `out_last`, `bus_r_w` = 0; `bus_addr`, `bus_wdata`, `out_data` = 0. State = IDLE.
- Reset asserted mid-job aborts immediately to these values. The TPU is not notified; the next job reloads all data.
- Bus write latency: a handshake in cycle k produces `bus_r_w`=1 in cycle k+1, with the matching address and data.
- Back-to-back handshakes give back-to-back bus writes.
- Minimum job length, with `load_c`=1, `in_valid` always 1, `out_ready` always 1: 1 (IDLE→LD_A) + 32 load + 1 GO + WAIT_CYC + 16*(RD_LAT+2) cycles.
- `start` while `busy` has no effect.
- `in_valid` outside the load states is ignored and consumes nothing.
- `out_ready` while `out_valid`=0 has no effect.
- The state change and the last bus write of each load state happen in the same cycle. There is no idle bubble between A, B and C writes.

## Test plan
- Full job, identity A, B = 1..64, `load_c`=0:
  - Bus shows writes 0x0100..0x0138, 0x0200..0x0238, 16 zero writes 0x0300..0x0378, then 0x0400.
  - 16 outputs equal to B rows packed as 16-bit lanes; `out_last` on the 16th; `done` one cycle later than the 16th handshake cycle's edge.
- Throttled input (`in_valid` toggling 1,0,1,0):
  - Write order and addresses are unchanged.
  - Idle bus cycles appear exactly where `in_valid`=0.
- Output backpressure (`out_ready` low for 5 cycles on word 3):
  - `out_data` and `out_valid` are stable throughout.
  - `bus_addr` stays at 0x0318; no word is lost or duplicated.
- `load_c`=1 with C-init all 0x0001 per lane:
  - 32 input words are consumed.
  - Outputs equal A×B + 1 in every lane.
- `start` pulsed during WAIT, plus `in_valid`=1 held during RD: no restart, no input consumed.
- Reset asserted in LD_B after 3 B writes:
  - All outputs read 0 in the next cycle and the FSM is in IDLE.
  - A fresh `start` completes a correct job.
